code_entry_fsm: RTL and testbench

//  Lock control stage between keypad scanner (newKey/keyCode) and displayInterface (dispVal/radixVal).
//  - Collects a CODE_LEN-digit hex code and compares it with a stored code.
//  - Drives the unlock and error LEDs and relocks using the door switch and a timeout.
//  - Allows the stored code to be changed while unlocked.

---
 rtl/code_entry_fsm.sv | 155 +++++++++++++++
 tb/tb_code_entry_fsm.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/code_entry_fsm.sv
// Keypad code-lock controller: collects a hex code, checks it against the stored
// code, drives the unlock/error LEDs and the display, and lets the code be changed.
module code_entry_fsm #(
  parameter int          CODE_LEN     = 4,
  parameter int          UNLOCK_TICKS = 25_000_000,
  parameter int          ERR_TICKS    = 10_000_000,
  parameter logic [15:0] DEFAULT_CODE = 16'h1234
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        newKey,
  input  logic [4:0]  keyCode,
  input  logic        switch,
  output logic        unlock,
  output logic        eLED,
  output logic [15:0] dispVal,
  output logic [3:0]  radixVal
);

  localparam int             MAX_TICKS   = (UNLOCK_TICKS > ERR_TICKS) ? UNLOCK_TICKS : ERR_TICKS;
  localparam int             TW          = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
  localparam logic [TW-1:0]  UNLOCK_LAST = TW'(UNLOCK_TICKS - 1);
  localparam logic [TW-1:0]  ERR_LAST    = TW'(ERR_TICKS - 1);
  localparam logic [2:0]     FULL        = 3'(CODE_LEN);
  localparam logic [15:0]    MASK        = 16'((32'd1 << (4 * CODE_LEN)) - 32'd1);

  typedef enum logic [2:0] {IDLE, ENTRY, CHECK, UNLOCKED, SET_ENTRY, ERROR} state_t;

  state_t        state, state_n;
  logic [15:0]   buffer, buffer_n, stored, stored_n;
  logic [2:0]    count, count_n;
  logic [TW-1:0] timer, timer_n;
  logic          hold, hold_n, sw_q;
  logic          unlock_n, eled_n;
  logic [15:0]   disp_n;
  logic [3:0]    radix_n;

  logic key_digit, key_enter, key_clear, key_set, sw_rise, match;
  assign key_digit = newKey && !keyCode[4];
  assign key_enter = newKey && (keyCode == 5'h10);
  assign key_clear = newKey && (keyCode == 5'h11);
  assign key_set   = newKey && (keyCode == 5'h12);
  assign sw_rise   = switch && !sw_q;
  assign match     = (buffer & MASK) == (stored & MASK);

  always_comb begin
    state_n  = state;
    buffer_n = buffer;
    count_n  = count;
    timer_n  = timer;
    stored_n = stored;
    hold_n   = hold;
    unlock_n = 1'b0;
    eled_n   = 1'b0;
    disp_n   = '0;
    radix_n  = '0;

    if (key_digit && count < FULL &&
        (state == IDLE || state == ENTRY || state == SET_ENTRY)) begin
      buffer_n = {buffer[11:0], keyCode[3:0]};
      count_n  = count + 3'd1;
    end

    case (state)
      IDLE:      if (key_digit) state_n = ENTRY;
      ENTRY: begin
        if (key_clear)      state_n = IDLE;
        else if (key_enter) state_n = (count == FULL) ? CHECK : ERROR;
      end
      CHECK:     state_n = match ? UNLOCKED : ERROR;
      UNLOCKED: begin
        // relock wins over a SET arriving on the same cycle
        if (sw_rise || (switch && timer == UNLOCK_LAST)) state_n = IDLE;
        else if (key_set)                                 state_n = SET_ENTRY;
      end
      SET_ENTRY: begin
        if (key_clear) state_n = UNLOCKED;
        else if (key_enter) begin
          if (count == FULL) begin
            stored_n = buffer;
            state_n  = UNLOCKED;
          end else begin
            hold_n  = 1'b1;
            state_n = ERROR;
          end
        end
      end
      ERROR:     if (timer == ERR_LAST) state_n = IDLE;
      default:   state_n = IDLE;
    endcase

    // one shared timer: every state change restarts it, saturating otherwise
    if (state_n != state) timer_n = '0;
    else if (state == ERROR || (state == UNLOCKED && switch))
      timer_n = (&timer) ? timer : timer + TW'(1);

    if (state_n == IDLE || state_n == UNLOCKED || state_n == ERROR) begin
      buffer_n = '0;
      count_n  = '0;
    end
    if (state_n != ERROR) hold_n = 1'b0;

    // outputs are decoded from the next state so they register with it
    case (state_n)
      ENTRY, CHECK: begin
        disp_n = buffer_n;
        for (int i = 0; i < 4; i++) radix_n[i] = (3'(i) < count_n);
      end
      UNLOCKED: begin
        unlock_n = 1'b1;
        disp_n   = 16'hAAAA;
      end
      SET_ENTRY: begin
        unlock_n = 1'b1;
        disp_n   = buffer_n;
        radix_n  = 4'hF;
      end
      ERROR: begin
        unlock_n = hold_n;
        eled_n   = 1'b1;
        disp_n   = 16'hEEEE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      buffer   <= '0;
      count    <= '0;
      timer    <= '0;
      stored   <= DEFAULT_CODE;
      hold     <= 1'b0;
      sw_q     <= 1'b1;
      unlock   <= 1'b0;
      eLED     <= 1'b0;
      dispVal  <= '0;
      radixVal <= '0;
    end else begin
      state    <= state_n;
      buffer   <= buffer_n;
      count    <= count_n;
      timer    <= timer_n;
      stored   <= stored_n;
      hold     <= hold_n;
      sw_q     <= switch;
      unlock   <= unlock_n;
      eLED     <= eled_n;
      dispVal  <= disp_n;
      radixVal <= radix_n;
    end
  end

endmodule

// File: tb/tb_code_entry_fsm.sv
// Bench for code_entry_fsm: directed scenarios plus a randomized run scored
// against a mode-level model of the lock.
module tb_code_entry_fsm;
  localparam int UT = 30;
  localparam int ET = 20;
  localparam logic [4:0] K_ENTER = 5'h10, K_CLEAR = 5'h11, K_SET = 5'h12;

  logic clock = 1'b0, reset = 1'b1, newKey = 1'b0, switch = 1'b1;
  logic [4:0] keyCode = '0;
  logic unlock, eLED;
  logic [15:0] dispVal;
  logic [3:0] radixVal;
  logic [21:0] obs, want;
  int total = 0, bad = 0;

  code_entry_fsm #(.CODE_LEN(4), .UNLOCK_TICKS(UT), .ERR_TICKS(ET), .DEFAULT_CODE(16'h1234)) dut (
    .clock(clock), .reset(reset), .newKey(newKey), .keyCode(keyCode), .switch(switch),
    .unlock(unlock), .eLED(eLED), .dispVal(dispVal), .radixVal(radixVal));

  always #5 clock = ~clock;
  assign obs = {unlock, eLED, dispVal, radixVal};

  // ---------------- reference model ----------------
  localparam int M_IDLE = 0, M_ENTRY = 1, M_CHECK = 2, M_UNL = 3, M_SET = 4, M_ERR = 5;
  typedef struct packed {
    int mode; int nd; int entered; int code; int ticks; bit keep_open; bit last_sw;
  } mstate_t;
  mstate_t m;

  function automatic mstate_t mreset();
    mstate_t r;
    r.mode = M_IDLE; r.nd = 0; r.entered = 0; r.code = 'h1234;
    r.ticks = 0; r.keep_open = 1'b0; r.last_sw = 1'b1;
    return r;
  endfunction

  function automatic mstate_t mstep(mstate_t c, logic rst, logic nk, logic [4:0] kc, logic sw);
    mstate_t n;
    bit rise, digit, enter, clr, setk;
    int d;
    n = c;
    rise = sw && !c.last_sw;
    n.last_sw = sw;
    digit = nk && (kc < 5'd16);
    enter = nk && (kc == K_ENTER);
    clr   = nk && (kc == K_CLEAR);
    setk  = nk && (kc == K_SET);
    d = int'(kc) % 16;
    if (rst) return mreset();
    case (c.mode)
      M_IDLE: if (digit) begin n.mode = M_ENTRY; n.entered = d; n.nd = 1; end
      M_ENTRY, M_SET: begin
        if (digit) begin
          if (c.nd < 4) begin n.entered = (c.entered * 16 + d) % 65536; n.nd = c.nd + 1; end
        end else if (clr) begin
          n.mode = (c.mode == M_ENTRY) ? M_IDLE : M_UNL;
          n.entered = 0; n.nd = 0; n.ticks = 0;
        end else if (enter) begin
          if (c.nd == 4 && c.mode == M_ENTRY) n.mode = M_CHECK;
          else begin
            if (c.nd == 4) begin n.code = c.entered; n.mode = M_UNL; end
            else begin n.mode = M_ERR; n.keep_open = (c.mode == M_SET); end
            n.entered = 0; n.nd = 0; n.ticks = 0;
          end
        end
      end
      M_CHECK: begin
        n.mode = (c.entered == c.code) ? M_UNL : M_ERR;
        n.entered = 0; n.nd = 0; n.ticks = 0;
      end
      M_UNL: begin
        if (rise || (sw && c.ticks == UT - 1)) n.mode = M_IDLE;
        else if (setk) begin n.mode = M_SET; n.ticks = 0; end
        else if (sw) n.ticks = c.ticks + 1;
      end
      M_ERR: begin
        if (c.ticks == ET - 1) begin n.mode = M_IDLE; n.keep_open = 1'b0; end
        else n.ticks = c.ticks + 1;
      end
      default: n = mreset();
    endcase
    return n;
  endfunction

  function automatic logic [21:0] model_out(mstate_t c);
    logic u, e; logic [15:0] dv; logic [3:0] rv;
    u = (c.mode == M_UNL) || (c.mode == M_SET) || (c.mode == M_ERR && c.keep_open);
    e = (c.mode == M_ERR);
    dv = 16'h0; rv = 4'h0;
    if (c.mode == M_ENTRY || c.mode == M_CHECK) begin dv = 16'(c.entered); rv = 4'((1 << c.nd) - 1); end
    else if (c.mode == M_SET) begin dv = 16'(c.entered); rv = 4'hF; end
    else if (c.mode == M_UNL) dv = 16'hAAAA;
    else if (c.mode == M_ERR) dv = 16'hEEEE;
    return {u, e, dv, rv};
  endfunction

  always @(posedge clock) m <= mstep(m, reset, newKey, keyCode, switch);

  // ---------------- stimulus helpers (no checking) ----------------
  function automatic logic [21:0] pk(logic u, logic e, logic [15:0] d, logic [3:0] r);
    return {u, e, d, r};
  endfunction

  task automatic run(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic press(input logic [4:0] k);
    newKey = 1'b1; keyCode = k;
    @(negedge clock);
    newKey = 1'b0; keyCode = '0;
  endtask

  task automatic enter_code(input logic [15:0] code);
    for (int i = 3; i >= 0; i--) press(5'((code >> (4 * i)) & 16'hF));
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1; switch = 1'b1;
    run(3);
    want = pk(0, 0, 16'h0, 4'h0);
    total++; if (obs !== want) begin bad++; $display("FAIL reset_held got=%h want=%h", obs, want); end
    reset = 1'b0;
    run(2);
    total++; if (obs !== want) begin bad++; $display("FAIL reset_idle got=%h want=%h", obs, want); end
  endtask

  task automatic test_unlock();
    logic [15:0] d = 16'h0;
    for (int i = 1; i <= 4; i++) begin
      press(5'(i));
      d = d * 16 + 16'(i);
      want = pk(0, 0, d, 4'((1 << i) - 1));
      total++; if (obs !== want) begin bad++; $display("FAIL digit_%0d got=%h want=%h", i, obs, want); end
    end
    press(K_ENTER);
    want = pk(0, 0, 16'h1234, 4'hF);
    total++; if (obs !== want) begin bad++; $display("FAIL enter_plus1 got=%h want=%h", obs, want); end
    run(1);
    want = pk(1, 0, 16'hAAAA, 4'h0);
    total++; if (obs !== want) begin bad++; $display("FAIL enter_plus2 got=%h want=%h", obs, want); end
    switch = 1'b0; run(1);
    total++; if (obs !== want) begin bad++; $display("FAIL door_open got=%h want=%h", obs, want); end
    switch = 1'b1; run(2);
    want = pk(0, 0, 16'h0, 4'h0);
    total++; if (obs !== want) begin bad++; $display("FAIL door_close_relock got=%h want=%h", obs, want); end
  endtask

  task automatic test_error();
    int n = 1;
    enter_code(16'h1235);
    press(K_ENTER);
    run(1);
    want = pk(0, 1, 16'hEEEE, 4'h0);
    total++; if (obs !== want) begin bad++; $display("FAIL wrong_code got=%h want=%h", obs, want); end
    for (int i = 0; i < 200 && eLED === 1'b1; i++) begin
      run(1);
      if (eLED === 1'b1) n++;
    end
    total++; if (n != ET) begin bad++; $display("FAIL err_duration got=%0d want=%0d", n, ET); end
    want = pk(0, 0, 16'h0, 4'h0);
    total++; if (obs !== want) begin bad++; $display("FAIL err_to_idle got=%h want=%h", obs, want); end
  endtask

  task automatic test_short_clear();
    press(5'd1); press(5'd2); press(K_ENTER);
    want = pk(0, 1, 16'hEEEE, 4'h0);
    total++; if (obs !== want) begin bad++; $display("FAIL short_enter got=%h want=%h", obs, want); end
    press(5'd7);
    total++; if (obs !== want) begin bad++; $display("FAIL key_in_error got=%h want=%h", obs, want); end
    for (int i = 0; i < 100 && eLED === 1'b1; i++) run(1);
    press(5'd1); press(5'd2); press(5'd3);
    want = pk(0, 0, 16'h0123, 4'h7);
    total++; if (obs !== want) begin bad++; $display("FAIL three_digits got=%h want=%h", obs, want); end
    press(5'h15);
    total++; if (obs !== want) begin bad++; $display("FAIL unused_key got=%h want=%h", obs, want); end
    press(K_CLEAR);
    want = pk(0, 0, 16'h0, 4'h0);
    total++; if (obs !== want) begin bad++; $display("FAIL clear got=%h want=%h", obs, want); end
    press(K_ENTER);
    total++; if (obs !== want) begin bad++; $display("FAIL enter_in_idle got=%h want=%h", obs, want); end
  endtask

  task automatic test_door();
    enter_code(16'h1234); press(K_ENTER); run(1);
    switch = 1'b0;
    for (int i = 0; i < 3 * UT; i++) begin
      run(1);
      total++; if (unlock !== 1'b1) begin bad++; $display("FAIL door_hold_%0d got=%b want=1", i, unlock); end
    end
    switch = 1'b1; run(2);
    want = pk(0, 0, 16'h0, 4'h0);
    total++; if (obs !== want) begin bad++; $display("FAIL door_edge_relock got=%h want=%h", obs, want); end
  endtask

  task automatic test_set_code();
    int n = 0;
    enter_code(16'h1234); press(K_ENTER); run(1);
    press(K_SET);
    want = pk(1, 0, 16'h0, 4'hF);
    total++; if (obs !== want) begin bad++; $display("FAIL set_entry got=%h want=%h", obs, want); end
    enter_code(16'h9876);
    want = pk(1, 0, 16'h9876, 4'hF);
    total++; if (obs !== want) begin bad++; $display("FAIL set_digits got=%h want=%h", obs, want); end
    press(K_ENTER);
    want = pk(1, 0, 16'hAAAA, 4'h0);
    total++; if (obs !== want) begin bad++; $display("FAIL set_commit got=%h want=%h", obs, want); end
    for (int i = 0; i < UT + 50 && unlock === 1'b1; i++) begin run(1); n++; end
    total++; if (n != UT) begin bad++; $display("FAIL timeout_len got=%0d want=%0d", n, UT); end
    enter_code(16'h1234); press(K_ENTER); run(1);
    want = pk(0, 1, 16'hEEEE, 4'h0);
    total++; if (obs !== want) begin bad++; $display("FAIL old_code_rejected got=%h want=%h", obs, want); end
    for (int i = 0; i < 100 && eLED === 1'b1; i++) run(1);
    enter_code(16'h9876); press(K_ENTER); run(1);
    want = pk(1, 0, 16'hAAAA, 4'h0);
    total++; if (obs !== want) begin bad++; $display("FAIL new_code_accepted got=%h want=%h", obs, want); end
    press(K_SET); press(5'd5); press(K_ENTER);
    want = pk(1, 1, 16'hEEEE, 4'h0);
    total++; if (obs !== want) begin bad++; $display("FAIL set_short got=%h want=%h", obs, want); end
    for (int i = 0; i < 100 && eLED === 1'b1; i++) run(1);
    want = pk(0, 0, 16'h0, 4'h0);
    total++; if (obs !== want) begin bad++; $display("FAIL set_short_end got=%h want=%h", obs, want); end
    enter_code(16'h9876); press(K_ENTER); run(1);
    press(K_SET); press(5'd1); press(K_CLEAR);
    want = pk(1, 0, 16'hAAAA, 4'h0);
    total++; if (obs !== want) begin bad++; $display("FAIL set_clear got=%h want=%h", obs, want); end
    switch = 1'b0; run(1); switch = 1'b1; run(2);
  endtask

  task automatic test_reset_mid();
    enter_code(16'h9876); press(K_ENTER); run(1);
    press(K_SET); press(5'd1); press(5'd2);
    reset = 1'b1; run(1);
    want = pk(0, 0, 16'h0, 4'h0);
    total++; if (obs !== want) begin bad++; $display("FAIL reset_in_set got=%h want=%h", obs, want); end
    reset = 1'b0; run(1);
    enter_code(16'h1234); press(K_ENTER); run(1);
    want = pk(1, 0, 16'hAAAA, 4'h0);
    total++; if (obs !== want) begin bad++; $display("FAIL default_restored got=%h want=%h", obs, want); end
    switch = 1'b0; run(1); switch = 1'b1; run(2);
    press(5'd1); press(K_ENTER); run(3);
    reset = 1'b1; run(1);
    want = pk(0, 0, 16'h0, 4'h0);
    total++; if (obs !== want) begin bad++; $display("FAIL reset_in_error got=%h want=%h", obs, want); end
    reset = 1'b0; run(1);
    total++; if (obs !== want) begin bad++; $display("FAIL after_reset_error got=%h want=%h", obs, want); end
  endtask

  task automatic test_random();
    int r;
    reset = 1'b1; switch = 1'b1; run(2); reset = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 999) < 3);
      if ($urandom_range(0, 99) < 3) switch = ~switch;
      newKey = ($urandom_range(0, 99) < 40);
      r = int'($urandom_range(0, 99));
      if (r < 55) begin
        if (m.nd < 4 && $urandom_range(0, 3) != 0) keyCode = 5'((m.code >> (4 * (3 - m.nd))) & 15);
        else keyCode = 5'($urandom_range(0, 15));
      end
      else if (r < 70) keyCode = K_ENTER;
      else if (r < 77) keyCode = K_CLEAR;
      else if (r < 85) keyCode = K_SET;
      else keyCode = 5'($urandom_range(19, 31));
      run(1);
      want = model_out(m);
      total++; if (obs !== want) begin bad++; $display("FAIL random_%0d got=%h want=%h", i, obs, want); end
    end
    newKey = 1'b0; reset = 1'b0; switch = 1'b1;
  endtask

  initial begin
    test_reset();
    test_unlock();
    test_error();
    test_short_clear();
    test_door();
    test_set_code();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
